seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit common-anode 7-segment display. It drives a 3-bit digit select into the anode decoder, which outputs AN active-low and turns all anodes off when sel[2]=1. It also drives the shared active-low cathode bus (SEG, DP) from a shadowed 16-bit hex value. Between digits it inserts a blanking gap so no digit ghosts. New display values are accepted by a load handshake and applied only at frame boundaries, so a frame never shows a mix of old and new values.

Parameters:
DIGIT_CYCLES, 100000, clocks each digit is lit (SCAN dwell); minimum 2
GAP_CYCLES, 8, clocks of blanking between digits; minimum 1
CNT_W, 17, width of the dwell counter; must hold max(DIGIT_CYCLES, GAP_CYCLES)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan the display, 0 = display dark
value  in  16  hex digits; digit i = value[4i+3:4i]; digit 0 is rightmost
load  in  1  one-cycle strobe that captures value into the pending register
dp_in  in  4  per-digit decimal point, 1 = lit; sampled live, not shadowed
blank  in  4  per-digit force-off, 1 = dark; sampled live
lz_en  in  1  leading-zero suppression enable; sampled live
sel  out  3  to anode decoder; 3'b0dd selects digit dd, 3'b100 = all off
SEG  out  7  {g,f,e,d,c,b,a}, active-low
DP  out  1  decimal point, active-low
pending  out  1  1 while a loaded value is waiting for a frame boundary
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=3'b100, SEG=7'h7F, DP=1, pending=0, frame_done=0, shadow=16'h0000, digit=0, counter=0. Reset mid-scan takes effect immediately and the pending value is lost.
- All outputs are registered; each output changes on the clock edge where its state/digit changes.
- States:
  - IDLE: sel=3'b100, SEG=7'h7F, DP=1. When enable=1, go to SCAN with digit=0 and counter=0.
  - SCAN: sel={1'b0,digit}. SEG = decode(shadow nibble), unless that digit is suppressed, in which case SEG=7'h7F. DP = ~dp_in[digit] (the decimal point is not suppressed by lz). After DIGIT_CYCLES clocks, go to GAP.
  - GAP: sel=3'b100, SEG=7'h7F, DP=1 for GAP_CYCLES clocks. Then digit=digit+1 (wraps 3 to 0) and go to SCAN.
- Frame boundary: the GAP-to-SCAN edge where digit wraps 3 to 0. On that edge:
  - frame_done=1 for exactly one cycle.
  - If pending=1: shadow<=pending register and pending<=0. The new value is first shown on digit 0 of the new frame.
- enable=0 in SCAN or GAP: go to IDLE next edge with outputs dark. No frame_done is generated. Re-enable restarts at digit 0.
- Load handshake:
  - load=1 captures value and sets pending=1.
  - A load while pending=1 overwrites the pending register (last writer wins).
  - A load in IDLE updates shadow directly; pending stays 0.
  - A load coinciding with a frame boundary goes to the pending register. It is applied at the next boundary, not the current one.
- Suppression: digit i is dark if blank[i]=1.
  - With lz_en=1, digit i in {3,2,1} is also dark if nibbles i..3 of shadow are all zero.
  - Digit 0 is never lz-suppressed.
- Decode (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Timing: frame period = 4*(DIGIT_CYCLES+GAP_CYCLES) clocks. Never more than one sel value in 0..3 per cycle, and sel=3'b100 on every digit transition.

Test Plan:
- Reset/idle (DIGIT_CYCLES=4, GAP_CYCLES=1): hold rst_n=0, then release with enable=0 -> sel=3'b100, SEG=7'h7F, DP=1, pending=0 indefinitely.
- Basic scan: load value=16'h1A80 in IDLE, then enable=1 -> repeating sequence sel=000/SEG=1000000 for 4 clocks, 100 for 1 clock, 001/0000000, 100, 010/0001000, 100, 011/1111001, 100; frame_done pulses every 20 clocks.
- Deferred load: mid-frame load 16'h000F while showing 16'h1A80 -> pending=1, the rest of the frame still shows 1A80. At the boundary frame_done=1, pending=0, and digit 0 shows 0001110.
- Leading zeros/blank/DP: shadow=16'h0005, lz_en=1, dp_in=4'b0010, blank=0 -> digits 3 and 2 dark (SEG=7F), digit 1 SEG=7F with DP=0, digit 0 SEG=0010010. With lz_en=0 and blank=4'b0001, digit 0 is dark and digit 3 shows 1000000.
- Back-to-back loads and boundary collision: load 16'h1111, then 16'h2222 before the boundary -> 2222 is displayed. A load of 16'h3333 on the exact frame-boundary cycle is shown only after the following frame_done.
- Disable/reset mid-scan: drop enable in SCAN of digit 2 -> dark next edge with no frame_done, and re-enable starts at sel=000. Assert rst_n mid-GAP with pending=1 -> outputs dark immediately, pending=0, and shadow=0 after release.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if: load handshake, scan controls and display bus of the 7-segment scan controller
interface seg_scan_if;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_en;
  logic [2:0]  sel;
  logic [6:0]  SEG;
  logic        DP;
  logic        pending;
  logic        frame_done;
  modport master (
    output enable, value, load, dp_in, blank, lz_en,
    input  sel, SEG, DP, pending, frame_done
  );
  modport slave (
    input  enable, value, load, dp_in, blank, lz_en,
    output sel, SEG, DP, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scanner with blanking gaps and frame-synchronous value updates
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GAP_CYCLES   = 8,
  parameter int CNT_W        = 17
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;
  state_t st, st_n;
  logic [1:0] dig, dig_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0] shadow, shadow_n, pend_r, pend_r_n;
  logic pend_n, boundary, idle_load, dark;
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40; 4'h1: decode = 7'h79; 4'h2: decode = 7'h24; 4'h3: decode = 7'h30;
      4'h4: decode = 7'h19; 4'h5: decode = 7'h12; 4'h6: decode = 7'h02; 4'h7: decode = 7'h78;
      4'h8: decode = 7'h00; 4'h9: decode = 7'h10; 4'hA: decode = 7'h08; 4'hB: decode = 7'h03;
      4'hC: decode = 7'h46; 4'hD: decode = 7'h21; 4'hE: decode = 7'h06; default: decode = 7'h0E;
    endcase
  endfunction
  function automatic logic suppressed(input logic [1:0] d, input logic [15:0] s, input logic [3:0] blank, input logic lz);
    suppressed = blank[d] | (lz & (d == 2'd3 ? s[15:12] == 4'h0 :
                                   d == 2'd2 ? s[15:8] == 8'h0 :
                                   d == 2'd1 ? s[15:4] == 12'h0 : 1'b0));
  endfunction
  always_comb begin
    st_n = st;
    dig_n = dig;
    cnt_n = cnt + CNT_W'(1);
    boundary = 1'b0;
    if (!bus.enable) begin
      st_n = IDLE;
      dig_n = 2'd0;
      cnt_n = '0;
    end else if (st == IDLE) begin
      st_n = SCAN;
      dig_n = 2'd0;
      cnt_n = '0;
    end else if (st == SCAN && cnt == CNT_W'(DIGIT_CYCLES - 1)) begin
      st_n = GAP;
      cnt_n = '0;
    end else if (st == GAP && cnt == CNT_W'(GAP_CYCLES - 1)) begin
      st_n = SCAN;
      dig_n = dig + 2'd1;
      cnt_n = '0;
      boundary = dig == 2'd3;
    end
    idle_load = bus.load && st == IDLE;
    shadow_n = idle_load ? bus.value : (boundary && bus.pending) ? pend_r : shadow;
    pend_r_n = (bus.load && !idle_load) ? bus.value : pend_r;
    // a load on the boundary edge re-arms pending rather than being applied now
    pend_n = idle_load ? bus.pending : bus.load | (bus.pending & ~boundary);
    dark = st_n != SCAN || suppressed(dig_n, shadow_n, bus.blank, bus.lz_en);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      dig <= 2'd0;
      cnt <= '0;
      shadow <= 16'h0000;
      pend_r <= 16'h0000;
      bus.pending <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.sel <= 3'b100;
      bus.SEG <= 7'h7F;
      bus.DP <= 1'b1;
    end else begin
      st <= st_n;
      dig <= dig_n;
      cnt <= cnt_n;
      shadow <= shadow_n;
      pend_r <= pend_r_n;
      bus.pending <= pend_n;
      bus.frame_done <= boundary;
      bus.sel <= st_n == SCAN ? {1'b0, dig_n} : 3'b100;
      bus.SEG <= dark ? 7'h7F : decode(shadow_n[{dig_n, 2'b00} +: 4]);
      bus.DP <= st_n == SCAN ? ~bus.dp_in[dig_n] : 1'b1;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan order, frame-synchronous loads, suppression and reset
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  seg_scan_if bus();
  seg_scan_ctrl #(.DIGIT_CYCLES(4), .GAP_CYCLES(1), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [12:0] DARK = {3'b100, 7'h7F, 1'b1, 1'b0, 1'b0};
  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {bus.sel, bus.SEG, bus.DP, bus.pending, bus.frame_done};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got sel/seg/dp/pend/fd=%b_%h_%b_%b_%b exp %b_%h_%b_%b_%b", tag,
             obs[12:10], obs[9:3], obs[2], obs[1], obs[0], exp[12:10], exp[9:3], exp[2], exp[1], exp[0]);
    end
  endtask
  // segs = {s3,s2,s1,s0}, dpl = expected active-low DP per digit; la* = cycle index of a load (99 = none)
  task automatic frame(input string tag, input int ncyc, input logic fd0, input logic pend0,
                       input logic [27:0] segs, input logic [3:0] dpl,
                       input int la0, input logic [15:0] lv0, input int la1, input logic [15:0] lv1,
                       input int la2, input logic [15:0] lv2);
    for (int k = 0; k < ncyc; k++) begin
      int d;
      logic pend;
      @(negedge clk);
      d = k / 5;
      pend = pend0 | (la0 < k) | (la1 < k) | (la2 < k);
      if (k % 5 == 4) chk($sformatf("%s k=%0d gap", tag, k), {3'b100, 7'h7F, 1'b1, pend, 1'b0});
      else chk($sformatf("%s k=%0d d%0d", tag, k, d), {1'b0, 2'(d), segs[7*d +: 7], dpl[d], pend, fd0 && k == 0});
      bus.load = (k == la0 || k == la1 || k == la2);
      bus.value = k == la0 ? lv0 : k == la1 ? lv1 : k == la2 ? lv2 : 16'h0000;
    end
  endtask
  initial begin
    bus.enable = 1'b0; bus.value = 16'h0; bus.load = 1'b0;
    bus.dp_in = 4'h0; bus.blank = 4'h0; bus.lz_en = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset", DARK);
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); chk("idle", DARK); end
    bus.value = 16'h1A80; bus.load = 1'b1;
    @(negedge clk);
    chk("idle_load", DARK);
    bus.load = 1'b0; bus.enable = 1'b1;
    frame("f1", 20, 1'b0, 1'b0, {7'h79, 7'h08, 7'h00, 7'h40}, 4'hF, 99, 0, 99, 0, 99, 0);
    frame("f2", 20, 1'b1, 1'b0, {7'h79, 7'h08, 7'h00, 7'h40}, 4'hF, 99, 0, 99, 0, 99, 0);
    frame("defer", 20, 1'b1, 1'b0, {7'h79, 7'h08, 7'h00, 7'h40}, 4'hF, 5, 16'h000F, 99, 0, 99, 0);
    frame("apply", 20, 1'b1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h0E}, 4'hF, 2, 16'h0005, 99, 0, 99, 0);
    bus.lz_en = 1'b1; bus.dp_in = 4'b0010;
    frame("lz_dp", 20, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1101, 99, 0, 99, 0, 99, 0);
    bus.lz_en = 1'b0; bus.dp_in = 4'b0000; bus.blank = 4'b0001;
    frame("blank", 20, 1'b1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h7F}, 4'hF, 99, 0, 99, 0, 99, 0);
    bus.blank = 4'b0000;
    frame("b2b", 20, 1'b1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 1, 16'h1111, 3, 16'h2222, 19, 16'h3333);
    frame("last_wins", 20, 1'b1, 1'b1, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 99, 0, 99, 0, 99, 0);
    frame("collide", 20, 1'b1, 1'b0, {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF, 99, 0, 99, 0, 99, 0);
    frame("pre_dis", 11, 1'b1, 1'b0, {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF, 99, 0, 99, 0, 99, 0);
    bus.enable = 1'b0;
    repeat (2) begin @(negedge clk); chk("disabled", DARK); end
    bus.enable = 1'b1;
    frame("reen", 5, 1'b0, 1'b0, {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF, 2, 16'h4444, 99, 0, 99, 0);
    rst_n = 1'b0;
    #1 chk("async_rst", DARK);
    @(negedge clk);
    chk("in_rst", DARK);
    rst_n = 1'b1;
    frame("post_rst", 20, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 99, 0, 99, 0, 99, 0);
    frame("post_fd", 1, 1'b1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 99, 0, 99, 0, 99, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
